ahb_master_arbiter: RTL

- Shares one AHB-Lite slave port between NUM_MASTERS AHB-Lite masters.
- Uses round-robin arbitration with a registered grant.
- Contains an address-phase mux, a data-phase hwdata mux and per-master hready generation.
- Sits between the master agent BFMs and the slave BFM/assertion interface in hdlTop. Each master sees a compliant AHB-Lite slave; the slave sees a single compliant master.

---
 rtl/ahb_master_arbiter_pkg.sv | 32 +++
 rtl/ahb_rr_arbiter.sv | 35 +++
 rtl/ahb_master_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite types and defaults for the multi-master arbiter slice.
package ahb_master_arbiter_pkg;

  // Default number of masters sharing the slave port.
  localparam int AHB_NUM_MASTERS = 2;

  // The address-phase struct carries haddr at the widest supported width;
  // instances narrower than this zero-extend on the way in and truncate on the way out.
  localparam int AHB_MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef struct packed {
    logic [AHB_MAX_ADDR_WIDTH-1:0] haddr;
    htrans_e                       htrans;
    logic                          hwrite;
    logic [2:0]                    hsize;
    logic [2:0]                    hburst;
    logic [3:0]                    hprot;
  } addr_phase_t;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin search: first requester at or after rr_ptr.
module ahb_rr_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = AHB_NUM_MASTERS,
  localparam int IW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          rr_ptr,
  input  logic                   arb_en,
  output logic                   grant_valid,
  output logic [IW-1:0]          grant_idx
);

  // Candidate index base+k, wrapped into 0..NUM_MASTERS-1.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return IW'(sum);
  endfunction

  // Walk the ring from rr_ptr and take the first requester found.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (arb_en && !grant_valid && req[rr_index(rr_ptr, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(rr_ptr, k);
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite slave port between NUM_MASTERS masters with a
// registered round-robin grant, address/data muxes and per-master hready.
module ahb_master_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = AHB_NUM_MASTERS,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_HOLD    = 16,
  localparam int IW = $clog2(NUM_MASTERS),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MASTERS*2-1:0]      m_htrans,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [NUM_MASTERS*3-1:0]      m_hsize,
  input  logic [NUM_MASTERS*3-1:0]      m_hburst,
  input  logic [NUM_MASTERS*4-1:0]      m_hprot,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
  input  logic [NUM_MASTERS*SW-1:0]     m_hwstrb,
  output logic [NUM_MASTERS-1:0]        m_hready,
  output logic [DATA_WIDTH-1:0]         m_hrdata,
  output logic                          m_hresp,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic [IW-1:0]                 hmaster,
  output logic [ADDR_WIDTH-1:0]         s_haddr,
  output logic [1:0]                    s_htrans,
  output logic                          s_hwrite,
  output logic [2:0]                    s_hsize,
  output logic [2:0]                    s_hburst,
  output logic [3:0]                    s_hprot,
  output logic [DATA_WIDTH-1:0]         s_hwdata,
  output logic [SW-1:0]                 s_hwstrb,
  output logic                          s_hselx,
  input  logic                          s_hreadyout,
  input  logic [DATA_WIDTH-1:0]         s_hrdata,
  input  logic                          s_hresp,
  output logic                          hold_err
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  addr_phase_t             ap    [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   wdata [NUM_MASTERS];
  logic [SW-1:0]           wstrb [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]  req;

  logic [IW-1:0] hmaster_reg, hmaster_next;
  logic [IW-1:0] downer_reg;
  logic          dphase_active_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          hold_err_reg;

  logic          arb_en;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          grant_change;
  addr_phase_t   sel;

  // Unpack the flat per-master buses into indexable arrays.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign ap[gi] = '{
      haddr:  AHB_MAX_ADDR_WIDTH'(m_haddr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      htrans: htrans_e'(m_htrans[gi*2 +: 2]),
      hwrite: m_hwrite[gi],
      hsize:  m_hsize[gi*3 +: 3],
      hburst: m_hburst[gi*3 +: 3],
      hprot:  m_hprot[gi*4 +: 4]
    };
    assign wdata[gi] = m_hwdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb[gi] = m_hwstrb[gi*SW +: SW];
    assign req[gi]   = (ap[gi].htrans != HTRANS_IDLE);
  end

  // Arbitrate only when the owner has gone IDLE, so bursts are never split.
  assign arb_en = s_hreadyout && !req[hmaster_reg];

  ahb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .req         (req),
    .rr_ptr      (rr_ptr_reg),
    .arb_en      (arb_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_change = grant_valid && (grant_idx != hmaster_reg);
  assign hmaster_next = grant_valid ? grant_idx : hmaster_reg;

  // Hold counter: run length of accepted non-IDLE owner transfers, saturating.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (s_hreadyout) begin
      if (grant_change || !req[hmaster_reg]) begin
        hold_cnt_next = '0;
      end else if (hold_cnt_reg != HW'(MAX_HOLD)) begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
      end
    end
  end

  // Grant, data-phase owner, round-robin pointer and hold monitor state.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hmaster_reg       <= '0;
      downer_reg        <= '0;
      dphase_active_reg <= 1'b0;
      rr_ptr_reg        <= IW'(1);
      hold_cnt_reg      <= '0;
      hold_err_reg      <= 1'b0;
    end else begin
      if (s_hreadyout) begin
        downer_reg        <= hmaster_reg;
        dphase_active_reg <= req[hmaster_reg];
      end
      hmaster_reg <= hmaster_next;
      if (grant_change) begin
        rr_ptr_reg <= IW'(wrap_inc(int'(grant_idx), NUM_MASTERS));
      end
      hold_cnt_reg <= hold_cnt_next;
      if (hold_cnt_next == HW'(MAX_HOLD)) begin
        hold_err_reg <= 1'b1;
      end
    end
  end

  // Address phase follows the grant; data phase follows the previous owner.
  assign sel      = ap[hmaster_reg];
  assign s_haddr  = ADDR_WIDTH'(sel.haddr);
  assign s_htrans = sel.htrans;
  assign s_hwrite = sel.hwrite;
  assign s_hsize  = sel.hsize;
  assign s_hburst = sel.hburst;
  assign s_hprot  = sel.hprot;
  assign s_hwdata = wdata[downer_reg];
  assign s_hwstrb = wstrb[downer_reg];
  assign s_hselx  = !hreset;

  assign m_hrdata = s_hrdata;
  assign m_hresp  = s_hresp;
  assign hmaster  = hmaster_reg;
  assign hold_err = hold_err_reg;

  // Owner and a live data phase see the slave's ready; waiting requesters stall.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_ready
    assign hgrant[gi]   = (hmaster_reg == IW'(gi));
    assign m_hready[gi] = (hmaster_reg == IW'(gi))                       ? s_hreadyout :
                          ((downer_reg == IW'(gi)) && dphase_active_reg) ? s_hreadyout :
                          req[gi]                                        ? 1'b0 : 1'b1;
  end

endmodule
